// File: rtl/mem_arbiter_if.sv
// Request/response bus between a memory master and a memory slave.
// One instance carries one bus: request channel (valid/ready, addr, wen,
// wdata, wstrb) and response channel (valid/ready, rdata, rsp_err).
//   master modport : drives the request fields and rsp_ready
//   slave modport  : drives req_ready and the response fields
interface mem_arbiter_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rdata;
    logic        rsp_err;

    modport master (
        output req_valid, addr, wen, wdata, wstrb, rsp_ready,
        input  req_ready, rsp_valid, rdata, rsp_err
    );

    modport slave (
        input  req_valid, addr, wen, wdata, wstrb, rsp_ready,
        output req_ready, rsp_valid, rdata, rsp_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master, one-slave memory arbiter with a single transaction in flight.
// m0 is the fetch port (read only), m1 the load/store port. Masters that are
// both requesting in IDLE are served round-robin. A transaction that does not
// finish within TIMEOUT cycles of its grant is completed towards the master
// with an error response.
// Ports:
//   clk    core clock, rising edge
//   rst_n  asynchronous active-low reset
//   m0     fetch bus (slave side of the interface)
//   m1     load/store bus (slave side of the interface)
//   s      memory bus (master side of the interface)
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_arbiter_if.slave   m0,
    mem_arbiter_if.slave   m1,
    mem_arbiter_if.master  s
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StTout} state_e;

    localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;           // 0: m0, 1: m1
    logic        last_owner_q, last_owner_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    logic grant_any;
    logic grant_m1;
    logic own_rsp_ready;
    logic timed_out;

    assign grant_any     = m0.req_valid | m1.req_valid;
    // m1 wins if it is alone, or if both request and m0 was served last
    assign grant_m1      = m1.req_valid & (~m0.req_valid | ~last_owner_q);
    assign own_rsp_ready = owner_q ? m1.rsp_ready : m0.rsp_ready;
    // >= rather than == so a count that passed the limit in REQ still expires in WAIT
    assign timed_out     = (cnt_q >= CntLast);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            cnt_q        <= '0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        case (state_q)
            StIdle: begin
                // req_ready follows the grant combinationally, so any valid is a handshake
                if (grant_any) begin
                    state_d      = StReq;
                    owner_d      = grant_m1;
                    last_owner_d = grant_m1;
                    cnt_d        = '0;
                    if (grant_m1) begin
                        addr_d  = m1.addr;
                        wen_d   = m1.wen;
                        wdata_d = m1.wdata;
                        wstrb_d = m1.wstrb;
                    end else begin
                        addr_d  = m0.addr;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        wstrb_d = '0;
                    end
                end
            end
            StReq: begin
                cnt_d = cnt_q + 16'd1;
                if (s.req_ready) begin
                    state_d = StWait;
                end else if (timed_out) begin
                    state_d = StTout;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 16'd1;
                if (s.rsp_valid && own_rsp_ready) begin
                    state_d = StIdle;
                end else if (timed_out) begin
                    state_d = StTout;
                end
            end
            StTout: begin
                if (own_rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        m0.req_ready = 1'b0;
        m1.req_ready = 1'b0;
        m0.rsp_valid = 1'b0;
        m0.rdata     = '0;
        m0.rsp_err   = 1'b0;
        m1.rsp_valid = 1'b0;
        m1.rdata     = '0;
        m1.rsp_err   = 1'b0;
        s.req_valid  = 1'b0;
        s.rsp_ready  = 1'b0;
        s.addr       = addr_q;
        s.wen        = wen_q;
        s.wdata      = wdata_q;
        s.wstrb      = wstrb_q;
        case (state_q)
            StIdle: begin
                // Gate with rst_n so no grant is visible while reset is held
                m0.req_ready = rst_n & grant_any & ~grant_m1;
                m1.req_ready = rst_n & grant_m1;
            end
            StReq: begin
                s.req_valid = 1'b1;
            end
            StWait: begin
                s.rsp_ready = own_rsp_ready;
                if (owner_q) begin
                    m1.rsp_valid = s.rsp_valid;
                    m1.rdata     = s.rdata;
                    m1.rsp_err   = s.rsp_err;
                end else begin
                    m0.rsp_valid = s.rsp_valid;
                    m0.rdata     = s.rdata;
                    m0.rsp_err   = s.rsp_err;
                end
            end
            StTout: begin
                if (owner_q) begin
                    m1.rsp_valid = 1'b1;
                    m1.rsp_err   = 1'b1;
                end else begin
                    m0.rsp_valid = 1'b1;
                    m0.rsp_err   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if m0_if ();
    mem_arbiter_if m1_if ();
    mem_arbiter_if s_if ();
    mem_arbiter_if m0t_if ();
    mem_arbiter_if m1t_if ();
    mem_arbiter_if st_if ();

    mem_arbiter #(.TIMEOUT(255)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if)
    );

    mem_arbiter #(.TIMEOUT(4)) u_dut_to (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0t_if),
        .m1    (m1t_if),
        .s     (st_if)
    );

    // Slave model for the main instance
    logic        slv_req_rdy;
    logic        slv_rsp_vld;
    logic        slv_use_addr;
    logic [31:0] slv_rdata;
    assign s_if.req_ready = slv_req_rdy;
    assign s_if.rsp_valid = slv_rsp_vld;
    assign s_if.rdata     = slv_use_addr ? ~s_if.addr : slv_rdata;
    assign s_if.rsp_err   = 1'b0;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    req_t exp_req_q[$];
    rsp_t exp_rsp0_q[$];
    rsp_t exp_rsp1_q[$];
    rsp_t exp_rspt_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // port 0/1: main m0/m1, 2: timeout-instance m1, 3: timeout-instance m0
    task automatic pop_rsp(input int port, input logic [31:0] rdata, input logic err);
        rsp_t e;
        bit   have;
        have = 1'b0;
        if (port == 0 && exp_rsp0_q.size() != 0) begin
            e = exp_rsp0_q.pop_front(); have = 1'b1;
        end else if (port == 1 && exp_rsp1_q.size() != 0) begin
            e = exp_rsp1_q.pop_front(); have = 1'b1;
        end else if (port == 2 && exp_rspt_q.size() != 0) begin
            e = exp_rspt_q.pop_front(); have = 1'b1;
        end
        if (!have) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected port %0d: got rdata 0x%08h err %0b, expected none",
                     port, rdata, err);
        end else begin
            check($sformatf("rsp%0d_rdata", port), rdata, e.rdata);
            check($sformatf("rsp%0d_err", port), {31'd0, err}, {31'd0, e.err});
        end
    endtask

    // Monitor: pops the scoreboard whenever a handshake is presented
    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_if.rsp_valid && m0_if.rsp_ready) pop_rsp(0, m0_if.rdata, m0_if.rsp_err);
            if (m1_if.rsp_valid && m1_if.rsp_ready) pop_rsp(1, m1_if.rdata, m1_if.rsp_err);
            if (m1t_if.rsp_valid && m1t_if.rsp_ready) pop_rsp(2, m1t_if.rdata, m1t_if.rsp_err);
            if (m0t_if.rsp_valid) pop_rsp(3, m0t_if.rdata, m0t_if.rsp_err);
            if (s_if.req_valid && s_if.req_ready) begin
                if (exp_req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected: got addr 0x%08h, expected none", s_if.addr);
                end else begin
                    req_t e;
                    e = exp_req_q.pop_front();
                    check("s_addr", s_if.addr, e.addr);
                    check("s_wen", {31'd0, s_if.wen}, {31'd0, e.wen});
                    check("s_wdata", s_if.wdata, e.wdata);
                    check("s_wstrb", {28'd0, s_if.wstrb}, {28'd0, e.wstrb});
                end
            end
        end
    end

    task automatic m0_issue(input logic [31:0] a);
        int n;
        n = 0;
        m0_if.req_valid = 1'b1;
        m0_if.addr      = a;
        @(negedge clk);
        while (!m0_if.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!m0_if.req_ready) begin
            checks++;
            errors++;
            $display("FAIL m0_grant: req_ready 0 after 100 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        m0_if.req_valid = 1'b0;
    endtask

    task automatic m1_issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] b);
        int n;
        n = 0;
        m1_if.req_valid = 1'b1;
        m1_if.addr      = a;
        m1_if.wen       = w;
        m1_if.wdata     = d;
        m1_if.wstrb     = b;
        @(negedge clk);
        while (!m1_if.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!m1_if.req_ready) begin
            checks++;
            errors++;
            $display("FAIL m1_grant: req_ready 0 after 100 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        m1_if.req_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        {m0_if.req_valid, m0_if.addr, m0_if.wen, m0_if.wdata, m0_if.wstrb} = '0;
        {m1_if.req_valid, m1_if.addr, m1_if.wen, m1_if.wdata, m1_if.wstrb} = '0;
        {m0t_if.req_valid, m0t_if.addr, m0t_if.wen, m0t_if.wdata, m0t_if.wstrb} = '0;
        {m1t_if.req_valid, m1t_if.addr, m1t_if.wen, m1t_if.wdata, m1t_if.wstrb} = '0;
        m0_if.rsp_ready  = 1'b1;
        m1_if.rsp_ready  = 1'b1;
        m0t_if.rsp_ready = 1'b1;
        m1t_if.rsp_ready = 1'b0;
        st_if.req_ready  = 1'b1;
        st_if.rsp_valid  = 1'b0;
        st_if.rdata      = '0;
        st_if.rsp_err    = 1'b0;
        slv_req_rdy  = 1'b0;
        slv_rsp_vld  = 1'b0;
        slv_use_addr = 1'b0;
        slv_rdata    = '0;

        // Reset state; a request during reset must not be granted
        m0_if.req_valid = 1'b1;
        m0_if.addr      = 32'h0000_1234;
        repeat (2) @(negedge clk);
        check("rst_m0_req_ready", {31'd0, m0_if.req_ready}, 32'd0);
        check("rst_s_req_valid", {31'd0, s_if.req_valid}, 32'd0);
        check("rst_s_rsp_ready", {31'd0, s_if.rsp_ready}, 32'd0);
        check("rst_s_addr", s_if.addr, 32'd0);
        check("rst_m0_rsp_valid", {31'd0, m0_if.rsp_valid}, 32'd0);
        check("rst_m1_rdata", m1_if.rdata, 32'd0);
        m0_if.req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Both masters requesting from reset: m0, m1, m0, m1
        slv_req_rdy  = 1'b1;
        slv_rsp_vld  = 1'b1;
        slv_use_addr = 1'b1;
        exp_req_q.push_back('{32'h1000_0000, 1'b0, 32'h0, 4'h0});
        exp_req_q.push_back('{32'h2000_0000, 1'b1, 32'hAAAA_5555, 4'hF});
        exp_req_q.push_back('{32'h1000_0004, 1'b0, 32'h0, 4'h0});
        exp_req_q.push_back('{32'h2000_0004, 1'b0, 32'h0, 4'h0});
        exp_rsp0_q.push_back('{32'hEFFF_FFFF, 1'b0});
        exp_rsp0_q.push_back('{32'hEFFF_FFFB, 1'b0});
        exp_rsp1_q.push_back('{32'hDFFF_FFFF, 1'b0});
        exp_rsp1_q.push_back('{32'hDFFF_FFFB, 1'b0});
        fork
            begin
                m0_issue(32'h1000_0000);
                m0_issue(32'h1000_0004);
            end
            begin
                m1_issue(32'h2000_0000, 1'b1, 32'hAAAA_5555, 4'hF);
                m1_issue(32'h2000_0004, 1'b0, 32'h0, 4'h0);
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Zero-wait read: response in the third cycle counting the grant cycle
        slv_use_addr = 1'b0;
        slv_rdata    = 32'h0000_0413;
        exp_req_q.push_back('{32'h8000_0000, 1'b0, 32'h0, 4'h0});
        exp_rsp0_q.push_back('{32'h0000_0413, 1'b0});
        m0_issue(32'h8000_0000);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m0_if.rsp_valid && n < 20);
        check("m0_rsp_latency", n, 32'd2);
        repeat (3) @(posedge clk);
        #1;

        // Write stalled by the slave: fields hold while s_req_ready is low
        slv_req_rdy = 1'b0;
        slv_rdata   = 32'h5555_AAAA;
        exp_req_q.push_back('{32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'b0011});
        exp_rsp1_q.push_back('{32'h5555_AAAA, 1'b0});
        m1_issue(32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'b0011);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_s_req_valid", {31'd0, s_if.req_valid}, 32'd1);
            check("stall_s_addr", s_if.addr, 32'h8000_0100);
            check("stall_s_wen", {31'd0, s_if.wen}, 32'd1);
            check("stall_s_wdata", s_if.wdata, 32'hDEAD_BEEF);
            check("stall_s_wstrb", {28'd0, s_if.wstrb}, 32'h3);
        end
        @(posedge clk);
        #1;
        slv_req_rdy = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Owner back-pressures the response for three cycles
        m0_if.rsp_ready = 1'b0;
        slv_rdata       = 32'h1111_2222;
        exp_req_q.push_back('{32'h8000_0200, 1'b0, 32'h0, 4'h0});
        exp_rsp0_q.push_back('{32'h1111_2222, 1'b0});
        m0_issue(32'h8000_0200);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_s_rsp_ready", {31'd0, s_if.rsp_ready}, 32'd0);
            check("hold_m0_rsp_valid", {31'd0, m0_if.rsp_valid}, 32'd1);
            check("hold_m0_rdata", m0_if.rdata, 32'h1111_2222);
            check("hold_m1_rsp_valid", {31'd0, m1_if.rsp_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        m0_if.rsp_ready = 1'b1;
        @(negedge clk);
        check("release_s_rsp_ready", {31'd0, s_if.rsp_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;

        // Reset in WAIT: outputs clear at once, abandoned transaction never answers
        m0_if.rsp_ready = 1'b0;
        slv_rdata       = 32'hCAFE_F00D;
        exp_req_q.push_back('{32'h8000_0300, 1'b0, 32'h0, 4'h0});
        m0_issue(32'h8000_0300);
        repeat (2) @(negedge clk);
        check("pre_rst_m0_rsp_valid", {31'd0, m0_if.rsp_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_m0_rsp_valid", {31'd0, m0_if.rsp_valid}, 32'd0);
        check("mid_rst_m0_rdata", m0_if.rdata, 32'd0);
        check("mid_rst_s_rsp_ready", {31'd0, s_if.rsp_ready}, 32'd0);
        check("mid_rst_s_addr", s_if.addr, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m0_if.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_m0_rsp_valid", {31'd0, m0_if.rsp_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        slv_rdata = 32'h600D_0000;
        exp_req_q.push_back('{32'h8000_0400, 1'b0, 32'h0, 4'h0});
        exp_rsp0_q.push_back('{32'h600D_0000, 1'b0});
        m0_issue(32'h8000_0400);
        repeat (4) @(posedge clk);
        #1;

        // TIMEOUT=4 instance: silent slave forces an error response
        exp_rspt_q.push_back('{32'h0, 1'b1});
        m1t_if.req_valid = 1'b1;
        m1t_if.addr      = 32'h8000_0500;
        @(negedge clk);
        check("to_grant", {31'd0, m1t_if.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        m1t_if.req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m1t_if.rsp_valid && n < 20);
        check("to_latency", n, 32'd5);
        check("to_rsp_err", {31'd0, m1t_if.rsp_err}, 32'd1);
        check("to_rdata", m1t_if.rdata, 32'd0);
        @(posedge clk);
        #1;
        st_if.rsp_valid = 1'b1;
        st_if.rdata     = 32'h1234_5678;
        @(negedge clk);
        check("to_late_rsp_valid", {31'd0, m1t_if.rsp_valid}, 32'd1);
        check("to_late_rdata", m1t_if.rdata, 32'd0);
        check("to_late_err", {31'd0, m1t_if.rsp_err}, 32'd1);
        check("to_late_s_rsp_ready", {31'd0, st_if.rsp_ready}, 32'd0);
        @(posedge clk);
        #1;
        m1t_if.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("to_idle_s_rsp_ready", {31'd0, st_if.rsp_ready}, 32'd0);
        @(posedge clk);
        #1;
        st_if.rsp_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("left_req", exp_req_q.size(), 32'd0);
        check("left_rsp0", exp_rsp0_q.size(), 32'd0);
        check("left_rsp1", exp_rsp1_q.size(), 32'd0);
        check("left_rspt", exp_rspt_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
